// File: rtl/fetch_sequencer.sv
// PC owner and instruction-memory fetch handshake for the five-stage core.
// Applies branch/flush redirects, buffers one word across stalls, and builds the stall vector.
module fetch_sequencer #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall_req_id,
    input  logic              i_stall_req_ex,
    input  logic              i_branch_flag,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_flush_target,
    input  logic              i_imem_ack,
    input  logic [31:0]       i_imem_rdata,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_ce,
    output logic              o_imem_req,
    output logic              o_inst_valid,
    output logic [31:0]       o_inst,
    output logic [5:0]        o_stall
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pending_pc;
    logic [31:0]       r_inst_buf;
    logic              r_outstanding;

    logic              w_hold;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_req;
    logic              w_busy;

    assign w_hold     = i_stall_req_id | i_stall_req_ex;
    assign w_redirect = i_flush | i_branch_flag;
    assign w_target   = i_flush ? i_flush_target : i_branch_target;
    assign w_pc_inc   = r_pc + ADDR_W'(4);

    // Once raised, the request is held until ack even if a stall arrives meanwhile.
    always_comb begin
        w_req = 1'b0;
        unique case (r_state)
            StFetch: w_req = r_outstanding | ~w_hold;
            StDrain: w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
    end

    always_comb begin
        o_inst_valid = 1'b0;
        o_inst       = 32'h0;
        if (r_state == StFetch && w_req && i_imem_ack && !w_redirect && !w_hold) begin
            o_inst_valid = 1'b1;
            o_inst       = i_imem_rdata;
        end else if (r_state == StHold && !w_redirect && !w_hold) begin
            o_inst_valid = 1'b1;
            o_inst       = r_inst_buf;
        end
    end

    assign w_busy = (w_req & ~i_imem_ack) | (r_state == StHold) | (r_state == StDrain);

    always_comb begin
        o_stall = 6'b0;
        if (!i_flush) begin
            o_stall[0] = w_busy | w_hold;
            o_stall[1] = w_busy | w_hold;
            o_stall[2] = w_hold;
            o_stall[3] = i_stall_req_ex;
        end
    end

    assign o_pc       = r_pc;
    assign o_ce       = (r_state != StIdle);
    assign o_imem_req = w_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_pc          <= RESET_PC;
            r_pending_pc  <= '0;
            r_inst_buf    <= 32'h0;
            r_outstanding <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: r_state <= StFetch;
                StFetch: begin
                    if (w_req && i_imem_ack) begin
                        r_outstanding <= 1'b0;
                        if (w_redirect) begin
                            r_pc <= w_target;
                        end else if (w_hold) begin
                            r_inst_buf <= i_imem_rdata;
                            r_pc       <= w_pc_inc;
                            r_state    <= StHold;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end else if (w_req) begin
                        r_outstanding <= 1'b1;
                        if (w_redirect) begin
                            r_pending_pc <= w_target;
                            r_state      <= StDrain;
                        end
                    end else if (w_redirect) begin
                        r_pc <= w_target;
                    end
                end
                StHold: begin
                    if (w_redirect) begin
                        r_inst_buf <= 32'h0;
                        r_pc       <= w_target;
                        r_state    <= StFetch;
                    end else if (!w_hold) begin
                        r_state <= StFetch;
                    end
                end
                StDrain: begin
                    // The in-flight word belongs to the old path; only its ack matters.
                    if (i_imem_ack) begin
                        r_outstanding <= 1'b0;
                        r_pc          <= w_redirect ? w_target : r_pending_pc;
                        r_state       <= StFetch;
                    end else if (w_redirect) begin
                        r_pending_pc <= w_target;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
